// File: rtl/dump_pkg.sv
// Shared types for the dat_mem result-region dump engine.
//   dump_state_t : sequencer states
//   PTR_W        : default dat_mem address (pointer) width
package dump_pkg;

    localparam int PTR_W = 8;

    // state | meaning
    // IDLE  | waiting for processor done
    // FETCH | driving dat_mem read port, capturing byte
    // SEND  | byte on stream, waiting for accept
    // CSUM  | checksum byte (last) on stream, waiting for accept
    // DONE  | dump finished, held until Start
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4
    } dump_state_t;

endpackage

// File: rtl/dump_csum.sv
// Mod-2**DW running checksum of dumped bytes.
//   clk      : system clock
//   clr      : synchronous clear (wins over add_en)
//   add_en   : add add_data this edge
//   add_data : byte to accumulate
//   sum      : current checksum
module dump_csum #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          add_en,
    input  logic [DW-1:0] add_data,
    output logic [DW-1:0] sum
);

    logic [DW-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (add_en) sum_d = sum_q + add_data;
    end

    always_ff @(posedge clk) begin
        if (clr) sum_q <= '0;
        else     sum_q <= sum_d;
    end

    assign sum = sum_q;

endmodule

// File: rtl/mem_dump.sv
// Readout engine for the dat_mem result region. After the processor raises
// done_in, reads COUNT bytes starting at BASE over a dedicated read port and
// streams them on a valid/ready interface, followed by a mod-256 checksum
// byte flagged with out_last. In top_level, rd_en selects rd_addr over
// acc_out on dat_mem's address mux, and rd_data is dat_mem's dat_out.
//   clk       : system clock
//   Start     : synchronous active-high reset
//   done_in   : processor done (level)
//   rd_en     : dump owns the dat_mem read port this cycle
//   rd_addr   : dat_mem read address
//   rd_data   : dat_mem read data (combinational from rd_addr)
//   out_data  : stream byte
//   out_valid : out_data valid
//   out_ready : sink accepts when out_valid & out_ready at an edge
//   out_last  : marks the checksum byte
//   dump_done : dump complete, held until Start
module mem_dump
    import dump_pkg::*;
#(
    parameter int AW    = PTR_W,
    parameter int DW    = 8,
    parameter int BASE  = 0,
    parameter int COUNT = 64
) (
    input  logic          clk,
    input  logic          Start,
    input  logic          done_in,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          dump_done
);

    // COUNT may equal 2**AW, so the transfer counter needs one extra bit.
    localparam int CW = AW + 1;

    dump_state_t   state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          dump_done_q, dump_done_d;
    logic          add_en;
    logic [DW-1:0] sum;

    dump_csum #(.DW(DW)) u_csum (
        .clk      (clk),
        .clr      (Start),
        .add_en   (add_en),
        .add_data (rd_data),
        .sum      (sum)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        dump_done_d = dump_done_q;
        rd_en       = 1'b0;
        add_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (done_in) state_d = FETCH;
            end
            FETCH: begin
                rd_en       = 1'b1;
                add_en      = 1'b1;
                out_data_d  = rd_data;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    ptr_d = ptr_q + AW'(1);
                    cnt_d = cnt_q + CW'(1);
                    // sum already includes this byte (added on the FETCH edge)
                    if (cnt_q == CW'(COUNT - 1)) begin
                        out_data_d = sum;
                        out_last_d = 1'b1;
                        state_d    = CSUM;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = FETCH;
                    end
                end
            end
            CSUM: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    dump_done_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Start) begin
            state_q     <= IDLE;
            ptr_q       <= AW'(BASE);
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            dump_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            dump_done_q <= dump_done_d;
        end
    end

    assign rd_addr   = ptr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign dump_done = dump_done_q;

endmodule

// File: tb/tb_mem_dump.sv
// Bench for mem_dump. Three instances share one byte memory:
//   0: BASE=0,   COUNT=4   (basic, random stall, abort, done held, same-edge)
//   1: BASE=254, COUNT=4   (address wrap)
//   2: BASE=5,   COUNT=1   (single byte)
// Expected bytes/last flags and read addresses are queued when a dump is
// launched and popped as the DUT transfers or fetches.
module tb_mem_dump;

    logic       clk = 1'b0;
    logic       start     [3];
    logic       done      [3];
    logic       out_ready [3];
    logic       rd_en     [3];
    logic [7:0] rd_addr   [3];
    logic [7:0] rd_data   [3];
    logic [7:0] out_data  [3];
    logic       out_valid [3];
    logic       out_last  [3];
    logic       dump_done [3];

    logic [7:0] mem [256];

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_data_q [$];
    logic       exp_last_q [$];
    logic [7:0] exp_addr_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_mem
        assign rd_data[g] = mem[rd_addr[g]];
    end

    mem_dump #(.AW(8), .DW(8), .BASE(0), .COUNT(4)) u_dut0 (
        .clk(clk), .Start(start[0]), .done_in(done[0]), .rd_en(rd_en[0]),
        .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .out_data(out_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_last(out_last[0]), .dump_done(dump_done[0]));

    mem_dump #(.AW(8), .DW(8), .BASE(254), .COUNT(4)) u_dut1 (
        .clk(clk), .Start(start[1]), .done_in(done[1]), .rd_en(rd_en[1]),
        .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .out_data(out_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_last(out_last[1]), .dump_done(dump_done[1]));

    mem_dump #(.AW(8), .DW(8), .BASE(5), .COUNT(1)) u_dut2 (
        .clk(clk), .Start(start[2]), .done_in(done[2]), .rd_en(rd_en[2]),
        .rd_addr(rd_addr[2]), .rd_data(rd_data[2]), .out_data(out_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_last(out_last[2]), .dump_done(dump_done[2]));

    // Hold Start for two edges; returns at a negedge with Start low.
    task automatic do_reset(input int idx);
        start[idx] = 1'b1;
        done[idx]  = 1'b0;
        out_ready[idx] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start[idx] = 1'b0;
    endtask

    // Launch a dump on instance idx and scoreboard the whole stream.
    // Entered and left at a negedge.
    task automatic run_stream(input int idx, input int base, input int count,
                              input int duty, input bit hold_done, input string tag);
        logic [7:0] sum;
        logic [7:0] a;
        logic [7:0] prev;
        logic [7:0] ed, ea;
        logic       el;
        bit         have_prev;
        bit         seen_valid;
        bit         rdy;
        int         n, cyc;
        exp_data_q.delete();
        exp_last_q.delete();
        exp_addr_q.delete();
        sum = 8'h00;
        for (int i = 0; i < count; i++) begin
            a = 8'((base + i) % 256);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem[a]);
            exp_last_q.push_back(1'b0);
            sum = sum + mem[a];
        end
        exp_data_q.push_back(sum);
        exp_last_q.push_back(1'b1);

        done[idx] = 1'b1;
        @(negedge clk);
        if (!hold_done) done[idx] = 1'b0;
        vectors++;
        if (rd_en[idx] !== 1'b1) begin
            miscompares++;
            $display("FAIL %s first_fetch: rd_en=%b need 1", tag, rd_en[idx]);
        end

        n = 0; cyc = 0; have_prev = 0; seen_valid = 0; prev = 8'h00;
        while (n < count + 1 && cyc < 2000) begin
            if (rd_en[idx] === 1'b1) begin
                vectors++;
                if (exp_addr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s extra_fetch: rd_addr=%0d need none", tag, rd_addr[idx]);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (rd_addr[idx] !== ea) begin
                        miscompares++;
                        $display("FAIL %s rd_addr: got %0d need %0d", tag, rd_addr[idx], ea);
                    end
                end
            end
            if (out_valid[idx] === 1'b1) begin
                if (!seen_valid) begin
                    seen_valid = 1;
                    vectors++;
                    if (cyc != 1) begin
                        miscompares++;
                        $display("FAIL %s first_valid_latency: got %0d need 1", tag, cyc);
                    end
                end
                if (have_prev) begin
                    vectors++;
                    if (out_data[idx] !== prev) begin
                        miscompares++;
                        $display("FAIL %s stall_hold: got %h need %h", tag, out_data[idx], prev);
                    end
                end
                rdy = ($urandom_range(99) < duty);
                out_ready[idx] = rdy;
                if (rdy) begin
                    ed = exp_data_q.pop_front();
                    el = exp_last_q.pop_front();
                    vectors++;
                    if (out_data[idx] !== ed || out_last[idx] !== el) begin
                        miscompares++;
                        $display("FAIL %s xfer%0d: got %h/last=%b need %h/last=%b",
                                 tag, n, out_data[idx], out_last[idx], ed, el);
                    end
                    n++;
                    have_prev = 0;
                end else begin
                    have_prev = 1;
                    prev = out_data[idx];
                end
            end else begin
                have_prev = 0;
                out_ready[idx] = ($urandom_range(99) < duty);
            end
            @(negedge clk);
            cyc++;
        end
        out_ready[idx] = 1'b1;
        vectors++;
        if (n != count + 1) begin
            miscompares++;
            $display("FAIL %s timeout: got %0d transfers need %0d", tag, n, count + 1);
        end
        vectors++;
        if (dump_done[idx] !== 1'b1 || out_valid[idx] !== 1'b0 || out_last[idx] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s dump_done: done=%b valid=%b last=%b need 1/0/0",
                     tag, dump_done[idx], out_valid[idx], out_last[idx]);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) do_reset(i);
        vectors++;
        if (rd_en[0] !== 1'b0 || out_valid[0] !== 1'b0 || out_last[0] !== 1'b0 ||
            dump_done[0] !== 1'b0 || out_data[0] !== 8'h00 || rd_addr[0] !== 8'd0) begin
            miscompares++;
            $display("FAIL reset0: rd_en=%b v=%b l=%b dd=%b d=%h a=%0d need all 0",
                     rd_en[0], out_valid[0], out_last[0], dump_done[0], out_data[0], rd_addr[0]);
        end
        vectors++;
        if (rd_addr[1] !== 8'd254 || out_valid[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset1_addr: got %0d/v=%b need 254/0", rd_addr[1], out_valid[1]);
        end
    endtask

    task automatic test_basic();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        do_reset(0);
        run_stream(0, 0, 4, 100, 1'b0, "basic");
    endtask

    task automatic test_wrap();
        mem[254] = 8'hFF; mem[255] = 8'hFF; mem[0] = 8'h01; mem[1] = 8'h01;
        do_reset(1);
        run_stream(1, 254, 4, 100, 1'b0, "wrap");
    endtask

    task automatic test_single();
        mem[5] = 8'h5A;
        do_reset(2);
        run_stream(2, 5, 1, 100, 1'b0, "single");
    endtask

    task automatic test_random_stall();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) mem[i] = 8'($urandom_range(255));
            do_reset(0);
            run_stream(0, 0, 4, 30, 1'b0, "stall");
        end
    endtask

    task automatic test_abort();
        int cyc;
        for (int i = 0; i < 4; i++) mem[i] = 8'h10 + 8'(i);
        do_reset(0);
        out_ready[0] = 1'b1;
        done[0] = 1'b1;
        @(negedge clk);
        done[0] = 1'b0;
        cyc = 0;
        while (out_valid[0] !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        @(negedge clk);           // first byte accepted on this edge
        out_ready[0] = 1'b0;
        cyc = 0;
        while (out_valid[0] !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        vectors++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h11) begin
            miscompares++;
            $display("FAIL abort_byte2: valid=%b data=%h need 1/11", out_valid[0], out_data[0]);
        end
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        out_ready[0] = 1'b1;
        vectors++;
        if (out_valid[0] !== 1'b0 || out_last[0] !== 1'b0 || out_data[0] !== 8'h00 ||
            rd_en[0] !== 1'b0 || dump_done[0] !== 1'b0 || rd_addr[0] !== 8'd0) begin
            miscompares++;
            $display("FAIL abort_clear: v=%b l=%b d=%h rd_en=%b dd=%b a=%0d need all 0",
                     out_valid[0], out_last[0], out_data[0], rd_en[0], dump_done[0], rd_addr[0]);
        end
        @(negedge clk);
        vectors++;
        if (rd_en[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: rd_en=%b valid=%b need 0/0", rd_en[0], out_valid[0]);
        end
        run_stream(0, 0, 4, 100, 1'b0, "restart");
    endtask

    task automatic test_done_held();
        do_reset(0);
        run_stream(0, 0, 4, 100, 1'b1, "held");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (rd_en[0] !== 1'b0 || dump_done[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL held_absorb: rd_en=%b dd=%b valid=%b need 0/1/0",
                         rd_en[0], dump_done[0], out_valid[0]);
            end
        end
        done[0] = 1'b0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        vectors++;
        if (dump_done[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL held_release: dump_done=%b need 0", dump_done[0]);
        end
    endtask

    task automatic test_same_edge();
        do_reset(0);
        start[0] = 1'b1;
        done[0]  = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        done[0]  = 1'b0;
        vectors++;
        if (rd_en[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL same_edge: rd_en=%b need 0", rd_en[0]);
        end
        @(negedge clk);
        vectors++;
        if (rd_en[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL same_edge_idle: rd_en=%b valid=%b need 0/0", rd_en[0], out_valid[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b1;
            done[i] = 1'b0;
            out_ready[i] = 1'b1;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_single();
        test_random_stall();
        test_abort();
        test_done_held();
        test_same_edge();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
